// File: rtl/mult2_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult2_seq_ctrl
//
// Purpose:
//    Computes the unsigned N x N product of op_a and op_b by using one
//    external combinational 2x2-bit multiplier. Each operand is split
//    into D = N/2 two-bit digits. One digit pair goes to the multiplier
//    per clock, and the 4-bit partial products are shifted and summed into
//    a 2N-bit accumulator. A full product takes D*D RUN cycles. Both the
//    operand side and the result side use a valid/ready handshake.
//
// Parameters:
//    N          operand width in bits. It must be even and at least 2.
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous, active-low reset
//    in_valid   op_a/op_b are valid
//    in_ready   the block can accept operands (high in IDLE only)
//    op_a       multiplicand, N bits
//    op_b       multiplier, N bits
//    mul_x      digit of A driven to the external multiplier (0 outside RUN)
//    mul_y      digit of B driven to the external multiplier (0 outside RUN)
//    mul_p      4-bit product returned by the external multiplier
//    out_valid  product is valid (high in DONE)
//    out_ready  the consumer accepts the product
//    product    2N-bit result. It holds its value until the next DONE entry.
//
// Build option:
//    ZERO_SKIP_EN  When this macro is defined, an accepted operand pair with
//                  a zero operand goes from IDLE to DONE with product 0. No
//                  RUN cycles occur in that case.
// -----------------------------------------------------------------------------
module mult2_seq_ctrl #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   op_a,
   input  logic [N-1:0]   op_b,
   output logic [1:0]     mul_x,
   output logic [1:0]     mul_y,
   input  logic [3:0]     mul_p,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product
);

   localparam int D  = N / 2;
   localparam int IW = (D > 1) ? $clog2(D) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(D - 1);
   localparam logic [IW-1:0] I_ONE  = IW'(1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]     state_reg, state_next;
   logic [N-1:0]   a_reg, a_next;
   logic [N-1:0]   b_reg, b_next;
   logic [2*N-1:0] acc_reg, acc_next;
   logic [2*N-1:0] prod_reg, prod_next;
   // The digit counter k is held as the pair (i, j): k = j*D + i.
   // This avoids a divider and a modulo on the counter path.
   logic [IW-1:0]  i_reg, i_next;
   logic [IW-1:0]  j_reg, j_next;

   logic [1:0]     a_dig [D];
   logic [1:0]     b_dig [D];
   logic [IW+1:0]  shamt;
   logic [2*N-1:0] pp_shifted;
   logic [2*N-1:0] acc_sum;

   // Split the registered operands into 2-bit digits.
   genvar gi;
   generate
      for (gi = 0; gi < D; gi++) begin : g_digits
         assign a_dig[gi] = a_reg[2*gi +: 2];
         assign b_dig[gi] = b_reg[2*gi +: 2];
      end
   endgenerate

   // The digit pair goes to the external multiplier only in RUN.
   // In IDLE and DONE the multiplier inputs are held at 0.
   assign mul_x = (state_reg == RUN) ? a_dig[i_reg] : 2'b00;
   assign mul_y = (state_reg == RUN) ? b_dig[j_reg] : 2'b00;

   // The partial-product weight is 4^(i+j), which is a left shift by 2*(i+j).
   assign shamt      = {({1'b0, i_reg} + {1'b0, j_reg}), 1'b0};
   assign pp_shifted = (2*N)'(mul_p) << shamt;
   assign acc_sum    = acc_reg + pp_shifted;

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign product   = prod_reg;

   // Next-state logic. acc_sum depends on mul_p, so it is used only in the
   // RUN branch. Outside RUN, garbage on mul_p cannot reach any register.
   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      acc_next   = acc_reg;
      prod_next  = prod_reg;
      i_next     = i_reg;
      j_next     = j_reg;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               a_next     = op_a;
               b_next     = op_b;
               acc_next   = '0;
               i_next     = '0;
               j_next     = '0;
               state_next = RUN;
`ifdef ZERO_SKIP_EN
               // The product is already known to be zero, so skip RUN.
               if ((op_a == '0) || (op_b == '0)) begin
                  prod_next  = '0;
                  state_next = DONE;
               end
`endif
            end
         end

         RUN: begin
            acc_next = acc_sum;
            if (i_reg == I_LAST) begin
               i_next = '0;
               if (j_reg == I_LAST) begin
                  // This is the last digit pair. Publish the completed sum
                  // directly, so product changes only when DONE is entered.
                  j_next     = '0;
                  prod_next  = acc_sum;
                  state_next = DONE;
               end else begin
                  j_next = j_reg + I_ONE;
               end
            end else begin
               i_next = i_reg + I_ONE;
            end
         end

         DONE: begin
            // in_valid is ignored here. A new accept is possible only after
            // one IDLE cycle.
            if (out_ready) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         prod_reg  <= '0;
         i_reg     <= '0;
         j_reg     <= '0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         acc_reg   <= acc_next;
         prod_reg  <= prod_next;
         i_reg     <= i_next;
         j_reg     <= j_next;
      end
   end

endmodule

// File: tb/tb_mult2_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult2_seq_ctrl
//
// Self-checking bench for mult2_seq_ctrl with N=8.
// - A behavioural 2x2 multiplier is attached to mul_x/mul_y/mul_p.
// - A time-based reference model records each accepted operand pair and
//   the accept cycle. From those it derives, every cycle:
//      in_ready, out_valid, product, mul_x, mul_y
//   using plain arithmetic: a*b, and the digits (a >> 2i) & 3.
// - Directed cases check literal values. Randomized cases ($urandom)
//   cover operands, backpressure and stray in_valid pulses.
// -----------------------------------------------------------------------------
module tb_mult2_seq_ctrl;
   localparam int N = 8;
   localparam int D = N / 2;
`ifdef ZERO_SKIP_EN
   localparam bit ZS = 1'b1;
`else
   localparam bit ZS = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic [N-1:0]   op_a = '0;
   logic [N-1:0]   op_b = '0;
   logic           in_ready;
   logic           out_valid;
   logic [1:0]     mul_x;
   logic [1:0]     mul_y;
   logic [3:0]     mul_p;
   logic [2*N-1:0] product;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b1;

   always #5 clk = ~clk;

   // External 2x2 combinational multiplier.
   assign mul_p = {2'b00, mul_x} * {2'b00, mul_y};

   mult2_seq_ctrl #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .mul_p     (mul_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int          cyc = 0;
   bit          busy = 1'b0;
   int          t_acc = 0;
   int unsigned ea = 0;
   int unsigned eb = 0;
   int unsigned last_prod = 0;

   // Number of clock edges after the accepting edge until out_valid is seen.
   // With zero skip, DONE is entered on the accepting edge itself.
   function automatic int lat(input int unsigned a, input int unsigned b);
      if (ZS && (a == 0 || b == 0)) return 0;
      return D * D;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         busy      = 1'b0;
         last_prod = 0;
      end else if (!busy) begin
         if (in_valid) begin
            busy  = 1'b1;
            t_acc = cyc;
            ea    = int'(op_a);
            eb    = int'(op_b);
         end
      end else if ((cyc - 1) >= t_acc + lat(ea, eb) && out_ready) begin
         busy      = 1'b0;
         last_prod = ea * eb;
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         bit          ov;
         bit          run;
         int          k;
         int unsigned ex;
         int unsigned ey;
         int unsigned ep;
         ov  = busy && (cyc >= t_acc + lat(ea, eb));
         run = busy && !ov;
         k   = cyc - t_acc;
         ex  = run ? ((ea >> (2 * (k % D))) & 3) : 0;
         ey  = run ? ((eb >> (2 * (k / D))) & 3) : 0;
         ep  = ov ? ea * eb : last_prod;
         check("in_ready",  64'(in_ready),  64'(!busy));
         check("out_valid", 64'(out_valid), 64'(ov));
         check("product",   64'(product),   64'(ep));
         check("mul_x",     64'(mul_x),     64'(ex));
         check("mul_y",     64'(mul_y),     64'(ey));
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input int unsigned a, input int unsigned b, input int bp, input bit noise,
                       output int lat_obs, output logic [1:0] fx, output logic [1:0] fy,
                       output logic [2*N-1:0] prod);
      int n;
      op_a     = a[N-1:0];
      op_b     = b[N-1:0];
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("accept_timeout", 64'(0), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      fx = mul_x;
      fy = mul_y;
      lat_obs = 0;
      while (!out_valid && lat_obs < 100) begin
         if (noise) begin
            in_valid = lat_obs[0];
            op_a = 8'd1;
            op_b = 8'd1;
         end
         @(posedge clk); #1;
         lat_obs++;
      end
      in_valid = 1'b0;
      if (!out_valid) check("done_timeout", 64'(0), 64'(1));
      prod = product;
      if (bp > 0) begin
         out_ready = 1'b0;
         repeat (bp) begin
            @(posedge clk); #1;
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int          l;
      logic [1:0]  fx, fy;
      logic [2*N-1:0] p;
      int unsigned ra, rb;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(in_ready),  64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_product",   64'(product),   64'(0));
      check("rst_mul",       64'({mul_x, mul_y}), 64'(0));
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // 13 x 11: latency, first digit pair, and result
      send(13, 11, 0, 1'b0, l, fx, fy, p);
      check("lat_13x11",  64'(l),  64'(16));
      check("k0_mul_x",   64'(fx), 64'(1));
      check("k0_mul_y",   64'(fy), 64'(3));
      check("prod_13x11", 64'(p),  64'(143));

      // Back-to-back max operands, then 2 x 128
      send(255, 255, 0, 1'b0, l, fx, fy, p);
      check("prod_255x255", 64'(p), 64'(65025));
      send(2, 128, 0, 1'b0, l, fx, fy, p);
      check("prod_2x128", 64'(p), 64'(256));

      // Zero operand
      send(0, 77, 0, 1'b0, l, fx, fy, p);
      check("prod_0x77", 64'(p), 64'(0));
      check("lat_0x77",  64'(l), ZS ? 64'(0) : 64'(16));

      // Backpressure
      send(200, 3, 10, 1'b0, l, fx, fy, p);
      check("prod_200x3", 64'(p), 64'(600));
      check("bp_in_ready_after", 64'(in_ready), 64'(1));

      // Stray in_valid pulses during RUN are ignored
      send(100, 100, 0, 1'b1, l, fx, fy, p);
      check("prod_100x100", 64'(p), 64'(10000));
      @(posedge clk); #1;
      check("no_second_accept_ready", 64'(in_ready),  64'(1));
      check("no_second_accept_valid", 64'(out_valid), 64'(0));

      // Asynchronous reset at k=7
      op_a = 8'd123;
      op_b = 8'd45;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      chk_en = 1'b0;
      check("pre_rst_mul_nonzero", 64'({mul_x, mul_y} != 4'b0000), 64'(1));
      rst_n = 1'b0;
      #1;
      check("async_in_ready",  64'(in_ready),  64'(1));
      check("async_out_valid", 64'(out_valid), 64'(0));
      check("async_product",   64'(product),   64'(0));
      check("async_mul",       64'({mul_x, mul_y}), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_no_valid", 64'(out_valid), 64'(0));
      send(9, 9, 0, 1'b0, l, fx, fy, p);
      check("prod_9x9", 64'(p), 64'(81));

      // Randomized traffic
      for (int it = 0; it < 30; it++) begin
         ra = $urandom_range(0, 255);
         rb = $urandom_range(0, 255);
         if ($urandom_range(0, 7) == 0) ra = 0;
         if ($urandom_range(0, 7) == 0) rb = 255;
         send(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), l, fx, fy, p);
         check("rand_prod", 64'(p), 64'(ra * rb));
         check("rand_lat",  64'(l), 64'(lat(ra, rb)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
